// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle 16-bit (WIDTH) shift/rotate unit.
// One power-of-two barrel stage is applied per clock edge. The accept edge
// already applies the first stage, so latency is max(1, popcount(shamt)) edges.
// Optional build macro ITER_SHIFTER_FIXED_LATENCY_EN: every request walks all
// SHAMT_W stages (MSB first), giving a constant latency of SHAMT_W edges.
// The result value is identical in both modes.
module iter_shifter #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_shamt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One barrel stage of 2^k. op[2] set selects ROR regardless of op[1:0].
  function automatic logic [WIDTH-1:0] apply_stage(
    input logic [WIDTH-1:0]   d,
    input logic [2:0]         op,
    input logic [SHAMT_W-1:0] k
  );
    logic [SHAMT_W:0]   amt;
    logic [SHAMT_W:0]   inv;
    logic [WIDTH-1:0]   r;
    amt = (SHAMT_W+1)'(1) << k;
    inv = (SHAMT_W+1)'(WIDTH) - amt;
    if (op[2]) begin
      r = (d >> amt) | (d << inv);
    end else begin
      case (op[1:0])
        2'b00:   r = (d << amt) | (d >> inv);
        2'b01:   r = d << amt;
        2'b10:   r = $signed(d) >>> amt;
        default: r = d >> amt;
      endcase
    end
    return r;
  endfunction

  // Index of the highest set bit (0 when the vector is empty).
  function automatic logic [SHAMT_W-1:0] hi_bit(input logic [SHAMT_W-1:0] v);
    logic [SHAMT_W-1:0] k;
    k = '0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (v[i]) k = SHAMT_W'(i);
    end
    return k;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [2:0]         op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;

  // Stage operand selection: in IDLE the stage works straight off the request
  // so the accept edge already makes progress; otherwise off the registers.
  logic [WIDTH-1:0]   sel_data;
  logic [2:0]         sel_op;
  logic [SHAMT_W-1:0] sel_rem;
  logic [SHAMT_W-1:0] sel_k;
  logic               sel_en;
  logic [WIDTH-1:0]   stage_out;

`ifdef ITER_SHIFTER_FIXED_LATENCY_EN
  logic [SHAMT_W-1:0] idx_q, idx_d;
`else
  logic [SHAMT_W-1:0] rem_clr;
`endif

  // Pick data/op/stage for the barrel stage used this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_data = data_q;
    sel_op   = op_q;
    sel_rem  = rem_q;
    if (state_q == IDLE) begin
      sel_data = in_data;
      sel_op   = in_op;
      sel_rem  = in_shamt;
    end
`ifdef ITER_SHIFTER_FIXED_LATENCY_EN
    sel_k  = (state_q == IDLE) ? SHAMT_W'(SHAMT_W-1) : idx_q;
    sel_en = sel_rem[sel_k];
`else
    sel_k  = hi_bit(sel_rem);
    sel_en = |sel_rem;
`endif
  end

  assign stage_out = sel_en ? apply_stage(sel_data, sel_op, sel_k) : sel_data;

`ifndef ITER_SHIFTER_FIXED_LATENCY_EN
  assign rem_clr = sel_rem & ~(SHAMT_W'(1) << sel_k);
`endif

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
`ifdef ITER_SHIFTER_FIXED_LATENCY_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = stage_out;
          op_d   = in_op;
`ifdef ITER_SHIFTER_FIXED_LATENCY_EN
          rem_d   = in_shamt;
          idx_d   = SHAMT_W'(SHAMT_W-2);
          state_d = SHIFT;
`else
          rem_d   = rem_clr;
          state_d = (rem_clr == '0) ? DONE : SHIFT;
`endif
        end
      end
      SHIFT: begin
        data_d = stage_out;
`ifdef ITER_SHIFTER_FIXED_LATENCY_EN
        if (idx_q == '0) state_d = DONE;
        else             idx_d   = idx_q - SHAMT_W'(1);
`else
        rem_d = rem_clr;
        if (rem_clr == '0) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
`ifdef ITER_SHIFTER_FIXED_LATENCY_EN
      idx_q   <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
`ifdef ITER_SHIFTER_FIXED_LATENCY_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;

endmodule
